// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Streams instruction bytes (most-significant byte first) into 32-bit words and
// writes them to an instruction memory starting at BASE_ADDR. The CPU holds its
// PC while busy_o is high; done_o pulses once when the session completes.
//
// Ports
//   clk_i       sole clock, rising edge
//   reset_i     synchronous active-high reset
//   start_i     one-cycle pulse starting a session (honoured in IDLE only)
//   len_i       number of words to load, clamped to DEPTH
//   in_data_i   next instruction byte
//   in_valid_i  in_data_i holds a valid byte
//   in_ready_o  loader accepts a byte this cycle (RECV only)
//   we_o        instruction-memory write strobe, one cycle per word
//   waddr_o     word-aligned byte address of the word being written
//   wdata_o     assembled instruction word
//   busy_o      session in progress
//   done_o      one-cycle pulse when a session completes
// -----------------------------------------------------------------------------
module inst_loader #(
    parameter int unsigned DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [5:0]  len_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [5:0]  DEPTH_LEN = 6'(DEPTH);
    // Highest word address the loader may ever present.
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

    state_t      state_q;
    logic [5:0]  word_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        in_ready_q;
    logic        we_q;
    logic        busy_q;
    logic        done_q;

    logic [5:0]  len_clamp_s;
    logic        accept_s;
    logic [31:0] wdata_d;

    // Length clamp, byte handshake and the shifted word for the next transfer.
    always_comb begin
        len_clamp_s = (len_i > DEPTH_LEN) ? DEPTH_LEN : len_i;
        accept_s    = in_valid_i & in_ready_q;
        // New byte enters at the LSB side so the first byte ends in [31:24].
        wdata_d     = {wdata_q[23:0], in_data_i};
    end

    // Loader state machine with registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            word_cnt_q <= 6'd0;
            byte_cnt_q <= 2'd0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (start_i) begin
                        word_cnt_q <= len_clamp_s;
                        addr_q     <= BASE_ADDR;
                        byte_cnt_q <= 2'd0;
                        busy_q     <= 1'b1;
                        if (len_clamp_s == 6'd0) begin
                            // Empty session: straight to FINISH, no writes.
                            state_q    <= FINISH;
                            done_q     <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q    <= RECV;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                RECV: begin
                    if (accept_s) begin
                        wdata_q    <= wdata_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // Word complete: strobe it next cycle, stop accepting.
                            state_q    <= WRITE;
                            we_q       <= 1'b1;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    we_q       <= 1'b0;
                    word_cnt_q <= word_cnt_q - 6'd1;
                    // Saturate so the address never runs past the memory.
                    if (addr_q < LAST_ADDR) begin
                        addr_q <= addr_q + 32'd4;
                    end
                    if (word_cnt_q == 6'd1) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= RECV;
                        in_ready_q <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                    we_q       <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    we_q       <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o = in_ready_q;
    assign we_o       = we_q;
    assign waddr_o    = addr_q;
    assign wdata_o    = wdata_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_inst_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_loader
// Directed bench for inst_loader. A session-level model (byte and word counts)
// predicts ready/we/busy/done and each written word; a compare process checks
// the DUT against it every cycle, and directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_inst_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  len;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready_o;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] wdata_o;
    logic        busy_o;
    logic        done_o;

    inst_loader #(.DEPTH(32), .BASE_ADDR(32'h0000_0000)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .len_i      (len),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_o),
        .we_o       (we_o),
        .waddr_o    (waddr_o),
        .wdata_o    (wdata_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int overlap = 0;
    bit chk_en  = 1'b0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- session-level model ----------------
    bit          m_busy, m_ready, m_we, m_done;
    bit          n_busy, n_ready, n_we, n_done;
    int          m_words, m_left, m_nbytes, m_widx;
    logic [31:0] m_cur, m_exp_addr, m_exp_data;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_ready = 1'b0; m_we = 1'b0; m_done = 1'b0;
            m_left = 0; m_nbytes = 0; m_widx = 0; m_cur = 32'd0;
        end else begin
            n_busy = m_busy; n_ready = m_ready; n_we = 1'b0; n_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_words  = (int'(len) > 32) ? 32 : int'(len);
                    m_left   = 4 * m_words;
                    m_nbytes = 0;
                    m_widx   = 0;
                    n_busy   = 1'b1;
                    n_ready  = (m_words != 0);
                    n_done   = (m_words == 0);
                end
            end else if (m_done) begin
                n_busy  = 1'b0;
                n_ready = 1'b0;
            end else if (m_we) begin
                m_widx++;
                n_ready = (m_left != 0);
                n_done  = (m_left == 0);
            end else if (m_ready && in_valid) begin
                m_cur = (m_cur << 8) | 32'(in_data);
                m_nbytes++;
                m_left--;
                if (m_nbytes % 4 == 0) begin
                    n_we       = 1'b1;
                    n_ready    = 1'b0;
                    m_exp_addr = 32'(4 * m_widx);
                    m_exp_data = m_cur;
                end
            end
            m_busy = n_busy; m_ready = n_ready; m_we = n_we; m_done = n_done;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check32("ready", 32'(in_ready_o), 32'(m_ready));
            check32("we",    32'(we_o),       32'(m_we));
            check32("busy",  32'(busy_o),     32'(m_busy));
            check32("done",  32'(done_o),     32'(m_done));
            if (m_we) begin
                check32("waddr", waddr_o, m_exp_addr);
                check32("wdata", wdata_o, m_exp_data);
            end
            if (we_o) begin
                obs_addr.push_back(waddr_o);
                obs_data.push_back(wdata_o);
            end
            if (we_o && in_ready_o) overlap++;
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic do_start(input logic [5:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        len   = 6'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_total++;
            $display("FAIL byte_accept_timeout: got no ready expected ready within 50 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy_o && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_total++;
            $display("FAIL idle_timeout: got busy expected idle within 500 cycles");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_ready"}, 32'(in_ready_o), 32'd0);
        check32({tag, "_we"},    32'(we_o),       32'd0);
        check32({tag, "_busy"},  32'(busy_o),     32'd0);
        check32({tag, "_done"},  32'(done_o),     32'd0);
        check32({tag, "_waddr"}, waddr_o,         32'd0);
        check32({tag, "_wdata"}, wdata_o,         32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int t;
        logic [7:0] b1 [4];
        reset = 1'b1; start = 1'b0; len = 6'd0; in_data = 8'd0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check_reset_outputs("rst");

        // Len=1, bytes 20 43 08 20
        base = obs_addr.size();
        b1[0] = 8'h20; b1[1] = 8'h43; b1[2] = 8'h08; b1[3] = 8'h20;
        do_start(6'd1);
        for (int i = 0; i < 4; i++) send_byte(b1[i], 0);
        check32("t1_we_after_4th", 32'(we_o), 32'd1);
        @(negedge clk);
        check32("t1_done", 32'(done_o), 32'd1);
        check32("t1_busy_in_done", 32'(busy_o), 32'd1);
        @(negedge clk);
        check32("t1_busy_after", 32'(busy_o), 32'd0);
        check32("t1_nwrites", 32'(obs_addr.size() - base), 32'd1);
        check32("t1_addr", obs_addr[base], 32'h0000_0000);
        check32("t1_data", obs_data[base], 32'h2043_0820);

        // Len=3, valid toggled every other cycle
        base = obs_addr.size();
        do_start(6'd3);
        for (int i = 0; i < 12; i++) send_byte(8'(8'h10 + i), 1);
        wait_idle();
        check32("t2_nwrites", 32'(obs_addr.size() - base), 32'd3);
        check32("t2_addr0", obs_addr[base],     32'h0);
        check32("t2_addr1", obs_addr[base + 1], 32'h4);
        check32("t2_addr2", obs_addr[base + 2], 32'h8);
        check32("t2_data0", obs_data[base],     32'h1011_1213);
        check32("t2_data2", obs_data[base + 2], 32'h1819_1A1B);

        // Len=0: one Done/Busy cycle, no writes
        base = obs_addr.size();
        do_start(6'd0);
        check32("t3_done", 32'(done_o), 32'd1);
        check32("t3_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        check32("t3_busy_after", 32'(busy_o), 32'd0);
        check32("t3_done_after", 32'(done_o), 32'd0);
        check32("t3_nwrites", 32'(obs_addr.size() - base), 32'd0);

        // Len=40 clamps to 32
        base = obs_addr.size();
        do_start(6'd40);
        for (int i = 0; i < 128; i++) send_byte(8'(i), 0);
        wait_idle();
        check32("t4_nwrites", 32'(obs_addr.size() - base), 32'd32);
        check32("t4_first_addr", obs_addr[base], 32'h0);
        check32("t4_first_data", obs_data[base], 32'h0001_0203);
        check32("t4_last_addr", obs_addr[obs_addr.size() - 1], 32'h7C);
        check32("t4_last_data", obs_data[obs_data.size() - 1], 32'h7C7D_7E7F);

        // Len=2, reset after 6 bytes
        base = obs_addr.size();
        do_start(6'd2);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("t5rst");
        repeat (4) @(negedge clk);
        check32("t5_nwrites", 32'(obs_addr.size() - base), 32'd1);
        check32("t5_data0", obs_data[base], 32'hA0A1_A2A3);
        do_start(6'd1);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 0);
        wait_idle();
        check32("t5_reload_addr", obs_addr[obs_addr.size() - 1], 32'h0);
        check32("t5_reload_data", obs_data[obs_data.size() - 1], 32'hC0C1_C2C3);

        // Start during RECV ignored; Start coinciding with Done ignored
        base = obs_addr.size();
        do_start(6'd2);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        do_start(6'd5);
        for (int i = 3; i <= 8; i++) send_byte(8'(i), 0);
        t = 0;
        while (!done_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        check32("t6_done_seen", 32'(done_o), 32'd1);
        do_start(6'd1);
        check32("t6_busy_after_done_start", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk);
        check32("t6_still_idle", 32'(busy_o), 32'd0);
        check32("t6_nwrites", 32'(obs_addr.size() - base), 32'd2);
        check32("t6_addr1", obs_addr[base + 1], 32'h4);
        check32("t6_data1", obs_data[base + 1], 32'h0506_0708);

        check32("ready_during_we", 32'(overlap), 32'd0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter DEPTH, 32, number of 32-bit instruction words in the target instruction memory; word index is Addr[6:2].
REQ-002 Parameter BASE_ADDR, 32'h0000_0000, byte address of the first word written.
REQ-003 Clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  one-cycle pulse that begins a load session.
REQ-006 Len  input  6  number of words to load, sampled on the accepted Start.
REQ-007 In_Data  input  8  next instruction byte, most-significant byte of each word first.
REQ-008 In_Valid  input  1  In_Data holds a valid byte.
REQ-009 In_Ready  output  1  loader accepts a byte this cycle.
REQ-010 We  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 WAddr  output  32  byte address of the word being written, word-aligned.
REQ-012 WData  output  32  assembled instruction word.
REQ-013 Busy  output  1  session in progress; the CPU holds its PC while high.
REQ-014 Done  output  1  one-cycle pulse when a session completes.

Function
REQ-015 The state machine SHALL have states IDLE, RECV, WRITE and FINISH.
REQ-016 In IDLE, Start=1 SHALL latch Len into a word counter, load the address register with BASE_ADDR, clear the byte counter and go to RECV.
REQ-017 A byte transfer SHALL occur only on a cycle with In_Valid=1 and In_Ready=1.
REQ-018 In_Ready SHALL be 1 only in RECV.
REQ-019 Transferred bytes SHALL be shifted into WData from the LSB side, so the first byte of a word ends in WData[31:24] and the fourth in WData[7:0].
REQ-020 A 2-bit byte counter SHALL increment per transfer and wrap 3->0.
REQ-021 On the fourth transfer of a word, the FSM SHALL go to WRITE.
REQ-022 In WRITE, We SHALL be 1 for exactly one cycle with stable WAddr/WData, so We rises the cycle after the fourth byte is accepted.
REQ-023 After WRITE, WAddr SHALL increase by 4 and the word counter SHALL decrement.
REQ-024 After WRITE, the FSM SHALL go to FINISH when the counter reaches 0, else to RECV.
REQ-025 Len=0 SHALL go directly IDLE->FINISH with no writes.
REQ-026 Len>DEPTH SHALL be clamped to DEPTH.
REQ-027 WAddr SHALL never exceed BASE_ADDR+4*(DEPTH-1) and SHALL NOT wrap.
REQ-028 FINISH SHALL last one cycle with Done=1 and then return to IDLE.
REQ-029 Busy SHALL be 1 in RECV, WRITE and FINISH, and 0 in IDLE.
REQ-030 Start SHALL be ignored outside IDLE.
REQ-031 A Start coinciding with Done SHALL be ignored.
REQ-032 In_Valid without In_Ready SHALL NOT change any state.
REQ-033 Gaps of any length in In_Valid SHALL only stall the session and SHALL NOT time out.
REQ-034 We SHALL never be asserted outside WRITE.
REQ-035 We SHALL never be asserted for a partially assembled word.

Reset
REQ-036 Reset=1 SHALL force IDLE on the next edge and override all other inputs.
REQ-037 Reset SHALL drive In_Ready=0, We=0, Busy=0, Done=0, WAddr=BASE_ADDR, WData=0, the byte counter to 0 and the word counter to 0.
REQ-038 Reset asserted mid-session SHALL discard any partial word, produce no further We, and not emit Done.

Verification
REQ-039 Start with Len=1; bytes 20,43,08,20 -> one We with WAddr=0x0 and WData=0x20430820; Done follows on the next cycle; Busy falls after Done.
REQ-040 Start with Len=3; 12 bytes with In_Valid toggled every other cycle -> three We pulses at WAddr 0x0, 0x4, 0x8 with words matching byte order; In_Ready=0 during each WRITE cycle.
REQ-041 Start with Len=0 -> no We; Done on the cycle after Start; Busy=1 for exactly that one cycle.
REQ-042 Start with Len=40 -> exactly 32 We pulses; last WAddr=0x7C; then Done.
REQ-043 Len=2; Reset after 6 bytes -> no second We; all outputs at reset values; new Start with Len=1 loads at WAddr=0x0.
REQ-044 Start pulsed during RECV with Len=5 -> ignored; the original session completes with its original Len.
